// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: shares one RF write port between the in-order
// pipeline (port 0) and a multi-cycle unit (port 1), and tracks pending writes for issue hazards.
module rf_wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            p0_valid,
    input  logic [4:0]      p0_rd,
    input  logic [XLEN-1:0] p0_data,
    output logic            p0_ready,
    input  logic            p1_valid,
    input  logic [4:0]      p1_rd,
    input  logic [XLEN-1:0] p1_data,
    output logic            p1_ready,
    input  logic            issue_valid,
    input  logic            issue_we,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic            issue_use1,
    input  logic            issue_use2,
    output logic            issue_stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     pending
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]   starve_cnt;
    logic            starved;
    logic            p1_win;
    logic            grant;
    logic [4:0]      grant_rd;
    logic [XLEN-1:0] grant_data;
    logic            haz_rs1;
    logic            haz_rs2;
    logic            haz_rd;
    logic            issue_fire;
    logic [31:0]     pending_q;
    logic [31:0]     pending_nxt;

    // Port 0 wins unless it is idle or port 1 has waited STARVE_LIMIT cycles.
    always_comb begin
        starved    = (starve_cnt == LIMIT);
        p1_win     = p1_valid && (!p0_valid || starved);
        p1_ready   = p1_win;
        p0_ready   = p0_valid && !p1_win;
        grant      = p0_ready || p1_ready;
        grant_rd   = p1_win ? p1_rd : p0_rd;
        grant_data = p1_win ? p1_data : p0_data;
    end

    always_comb begin
        haz_rs1     = issue_use1 && (issue_rs1 != 5'd0) && pending_q[issue_rs1];
        haz_rs2     = issue_use2 && (issue_rs2 != 5'd0) && pending_q[issue_rs2];
        haz_rd      = issue_we && (issue_rd != 5'd0) && pending_q[issue_rd];
        issue_stall = issue_valid && (haz_rs1 || haz_rs2 || haz_rd);
        issue_fire  = issue_valid && issue_we && !issue_stall && (issue_rd != 5'd0);
    end

    // Set is applied after clear so a same-edge issue on the retiring register keeps it pending.
    always_comb begin
        pending_nxt = pending_q;
        if (rf_we) begin
            pending_nxt[rf_waddr] = 1'b0;
        end
        if (issue_fire) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= '0;
            pending_q  <= 32'd0;
            starve_cnt <= '0;
        end else begin
            rf_we <= grant && (grant_rd != 5'd0);
            if (grant) begin
                rf_waddr <= grant_rd;
                rf_wdata <= grant_data;
            end
            pending_q <= pending_nxt;
            if (!p1_valid || p1_win) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

    assign pending = pending_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, contention/starvation,
// RAW/WAW scoreboard hazards, x0 handling and mid-operation reset.
module tb_rf_wb_arbiter;

    localparam int XLEN = 64;

    logic            clk;
    logic            nrst;
    logic            p0_valid;
    logic [4:0]      p0_rd;
    logic [XLEN-1:0] p0_data;
    logic            p0_ready;
    logic            p1_valid;
    logic [4:0]      p1_rd;
    logic [XLEN-1:0] p1_data;
    logic            p1_ready;
    logic            issue_valid;
    logic            issue_we;
    logic [4:0]      issue_rd;
    logic [4:0]      issue_rs1;
    logic [4:0]      issue_rs2;
    logic            issue_use1;
    logic            issue_use2;
    logic            issue_stall;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     pending;

    int checks;
    int failures;

    rf_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk(clk), .nrst(nrst),
        .p0_valid(p0_valid), .p0_rd(p0_rd), .p0_data(p0_data), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_rd(p1_rd), .p1_data(p1_data), .p1_ready(p1_ready),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use1(issue_use1), .issue_use2(issue_use2), .issue_stall(issue_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_valid    = 1'b0;
        p0_rd       = 5'd0;
        p0_data     = '0;
        p1_valid    = 1'b0;
        p1_rd       = 5'd0;
        p1_data     = '0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rd    = 5'd0;
        issue_rs1   = 5'd0;
        issue_rs2   = 5'd0;
        issue_use1  = 1'b0;
        issue_use2  = 1'b0;
    endtask

    task automatic test_reset();
        nrst     = 1'b0;
        p0_valid = 1'b1;
        p0_rd    = 5'd9;
        p0_data  = 64'hAA;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (rf_we !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_rf_we cycle %0d got=%b exp=0", i, rf_we);
            end
            checks++;
            if (pending !== 32'd0) begin
                failures++;
                $display("[TB] FAIL reset_pending cycle %0d got=%h exp=0", i, pending);
            end
            checks++;
            if (rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin
                failures++;
                $display("[TB] FAIL reset_waddr_wdata got=%0d/%h exp=0/0", rf_waddr, rf_wdata);
            end
        end
        nrst = 1'b1;
        tick();
        p0_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'hAA) begin
            failures++;
            $display("[TB] FAIL reset_release_write got=%b/%0d/%h exp=1/9/aa", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle_we got=%b exp=0", rf_we);
        end
    endtask

    task automatic test_single_write();
        p0_valid = 1'b1;
        p0_rd    = 5'd5;
        p0_data  = 64'h1234;
        #1;
        checks++;
        if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_ready got p0=%b p1=%b exp p0=1 p1=0", p0_ready, p1_ready);
        end
        tick();
        p0_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h1234) begin
            failures++;
            $display("[TB] FAIL single_write got=%b/%0d/%h exp=1/5/1234", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 64'h1234) begin
            failures++;
            $display("[TB] FAIL single_hold got=%b/%0d/%h exp=0/5/1234", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_contention();
        logic exp_p1;
        p0_valid = 1'b1;
        p0_rd    = 5'd1;
        p0_data  = 64'h1111;
        p1_valid = 1'b1;
        p1_rd    = 5'd2;
        p1_data  = 64'h2222;
        for (int i = 0; i < 10; i++) begin
            // Four port-0 grants, then port 1 on the fifth cycle, repeating.
            exp_p1 = (i % 5 == 4);
            #1;
            checks++;
            if (p1_ready !== exp_p1 || p0_ready !== !exp_p1) begin
                failures++;
                $display("[TB] FAIL contention_grant cycle %0d got p0=%b p1=%b exp p1=%b",
                         i, p0_ready, p1_ready, exp_p1);
            end
            @(posedge clk);
            #1;
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== (exp_p1 ? 5'd2 : 5'd1)) begin
                failures++;
                $display("[TB] FAIL contention_write cycle %0d got=%b/%0d exp=1/%0d",
                         i, rf_we, rf_waddr, exp_p1 ? 2 : 1);
            end
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        tick();
    endtask

    task automatic test_raw();
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = 5'd7;
        #1;
        checks++;
        if (issue_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL raw_producer_stall got=%b exp=0", issue_stall);
        end
        tick();
        checks++;
        if (pending[7] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL raw_pending_set got=%b exp=1", pending[7]);
        end
        issue_we   = 1'b0;
        issue_rd   = 5'd0;
        issue_use1 = 1'b1;
        issue_rs1  = 5'd7;
        #1;
        checks++;
        if (issue_stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL raw_stall_1 got=%b exp=1", issue_stall);
        end
        tick();
        p1_valid = 1'b1;
        p1_rd    = 5'd7;
        p1_data  = 64'h77;
        #1;
        checks++;
        if (issue_stall !== 1'b1 || p1_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL raw_stall_2 got stall=%b p1_ready=%b exp 1/1", issue_stall, p1_ready);
        end
        tick();
        p1_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || issue_stall !== 1'b1 || pending[7] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL raw_writeback_cycle got we=%b addr=%0d stall=%b pend=%b exp 1/7/1/1",
                     rf_we, rf_waddr, issue_stall, pending[7]);
        end
        tick();
        checks++;
        if (issue_stall !== 1'b0 || pending[7] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL raw_release got stall=%b pend=%b exp 0/0", issue_stall, pending[7]);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_waw();
        p0_valid = 1'b1;
        p0_rd    = 5'd3;
        p0_data  = 64'h33;
        tick();
        p0_valid    = 1'b0;
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = 5'd3;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || issue_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL waw_setup got we=%b addr=%0d stall=%b exp 1/3/0", rf_we, rf_waddr, issue_stall);
        end
        tick();
        checks++;
        if (pending[3] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL waw_set_over_clear got=%b exp=1", pending[3]);
        end
        checks++;
        if (issue_stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL waw_second_issue_stall got=%b exp=1", issue_stall);
        end
        tick();
        checks++;
        if (issue_stall !== 1'b1 || pending[3] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL waw_stall_hold got stall=%b pend=%b exp 1/1", issue_stall, pending[3]);
        end
        idle_inputs();
        p0_valid = 1'b1;
        p0_rd    = 5'd3;
        tick();
        p0_valid = 1'b0;
        tick();
        checks++;
        if (pending[3] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL waw_clear got=%b exp=0", pending[3]);
        end
    endtask

    task automatic test_x0();
        p1_valid    = 1'b1;
        p1_rd       = 5'd0;
        p1_data     = 64'hFFFF;
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = 5'd0;
        issue_use1  = 1'b1;
        issue_rs1   = 5'd0;
        #1;
        checks++;
        if (p1_ready !== 1'b1 || issue_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL x0_ready_stall got p1_ready=%b stall=%b exp 1/0", p1_ready, issue_stall);
        end
        tick();
        idle_inputs();
        checks++;
        if (rf_we !== 1'b0 || pending[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL x0_write got we=%b pend0=%b exp 0/0", rf_we, pending[0]);
        end
        checks++;
        if (pending !== 32'd0) begin
            failures++;
            $display("[TB] FAIL x0_pending got=%h exp=0", pending);
        end
    endtask

    task automatic test_reset_mid();
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = 5'd12;
        tick();
        issue_valid = 1'b0;
        checks++;
        if (pending !== 32'h0000_1000) begin
            failures++;
            $display("[TB] FAIL midreset_setup got=%h exp=00001000", pending);
        end
        p0_valid = 1'b1;
        p0_rd    = 5'd12;
        p0_data  = 64'hCC;
        nrst     = 1'b0;
        tick();
        p0_valid = 1'b0;
        nrst     = 1'b1;
        checks++;
        if (rf_we !== 1'b0 || pending !== 32'd0) begin
            failures++;
            $display("[TB] FAIL midreset_clear got we=%b pend=%h exp 0/0", rf_we, pending);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_after got=%b exp=0", rf_we);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nrst     = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_raw();
        test_waw();
        test_x0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
